// File: rtl/lzd_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : lzd_pipe_if
// Brief    : Word-in / result-out handshake bundle for the lzd_pipe scanner.
// Revision : 1.0
// ============================================================================
interface lzd_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  localparam int CW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_zero;
  logic [WIDTH-1:0] out_norm;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_count, out_zero, out_norm, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_count, out_zero, out_norm, out_tag
  );
endinterface
`default_nettype wire

// File: rtl/lzd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lzd_pipe
// Brief    : Pipelined leading-zero/one detector with staged normalisation.
// Revision : 1.0
// ============================================================================
module lzd_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  lzd_pipe_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int NP = WIDTH / 2;   // detector cells at tree level 0
  localparam int NG = WIDTH - 1;   // tree nodes over all levels

  // Nodes of every level live in one flat array; level l starts here.
  function automatic int base(input int l);
    return WIDTH - (WIDTH >> l);
  endfunction

  logic [CW-1:0]    vld_q, vld_d;
  logic [TAG_W-1:0] tag_q  [CW];
  logic [TAG_W-1:0] tag_d  [CW];
  logic             z_q    [NG];
  logic             z_d    [NG];
  logic [CW-1:0]    cnt_q  [NG];
  logic [CW-1:0]    cnt_d  [NG];
  logic [WIDTH-1:0] norm_q [NG];
  logic [WIDTH-1:0] norm_d [NG];

  logic             en;
  logic [WIDTH-1:0] x;
  logic             p;
  logic             sel_lo;
  int               lo, hi, dst;

  assign en            = bus.out_ready | ~vld_q[CW-1];
  assign bus.in_ready  = en | rst;
  assign bus.out_valid = vld_q[CW-1];
  assign bus.out_count = cnt_q[NG-1];
  assign bus.out_zero  = z_q[NG-1];
  assign bus.out_norm  = norm_q[NG-1];
  assign bus.out_tag   = tag_q[CW-1];

  // Each node keeps a candidate result: in_data pre-shifted so its own group
  // top sits at the MSB, then shifted by its local count. Merging is a pure
  // select; choosing the low half applies the 2^l shift for count bit l.
  always_comb begin
    vld_d  = vld_q;
    tag_d  = tag_q;
    z_d    = z_q;
    cnt_d  = cnt_q;
    norm_d = norm_q;
    x      = bus.in_data ^ {WIDTH{bus.in_mode}};
    p      = 1'b0;
    sel_lo = 1'b0;
    lo     = 0;
    hi     = 0;
    dst    = 0;
    if (en) begin
      vld_d = {vld_q[CW-2:0], bus.in_valid};
      if (bus.in_valid) begin
        tag_d[0] = bus.in_tag;
        for (int i = 0; i < NP; i++) begin
          p         = ~x[2*i+1] & x[2*i];
          z_d[i]    = ~(x[2*i+1] | x[2*i]);
          cnt_d[i]  = {{(CW-1){1'b0}}, p};
          norm_d[i] = bus.in_data << (WIDTH - 2 - 2*i + int'(p));
        end
      end
      for (int l = 1; l < CW; l++) begin
        if (vld_q[l-1]) begin
          tag_d[l] = tag_q[l-1];
          for (int j = 0; j < (NP >> l); j++) begin
            lo          = base(l-1) + 2*j;
            hi          = lo + 1;
            dst         = base(l) + j;
            sel_lo      = z_q[hi] & ~z_q[lo];
            z_d[dst]    = z_q[hi] & z_q[lo];
            cnt_d[dst]  = sel_lo ? (cnt_q[lo] | (CW'(1) << l)) : cnt_q[hi];
            norm_d[dst] = sel_lo ? norm_q[lo] : norm_q[hi];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < CW; k++) begin
        tag_q[k] <= '0;
      end
      for (int g = 0; g < NG; g++) begin
        z_q[g]    <= 1'b0;
        cnt_q[g]  <= '0;
        norm_q[g] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      tag_q  <= tag_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
      norm_q <= norm_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_lzd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_lzd_pipe
// Brief    : Self-checking bench for lzd_pipe (WIDTH=16, TAG_W=4).
// Revision : 1.0
// ============================================================================
module tb_lzd_pipe;
  localparam int W  = 16;
  localparam int TW = 4;
  localparam int CW = 4;
  localparam int NRAND = 12000;

  typedef struct packed {
    logic [CW-1:0] c;
    logic          z;
    logic [W-1:0]  n;
    logic [TW-1:0] t;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  res_t exp_q [$];

  lzd_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  lzd_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: walk from the MSB while bits equal the mode bit.
  function automatic res_t model(input logic [W-1:0] d, input logic m, input logic [TW-1:0] t);
    res_t r;
    int   k = 0;
    while (k < W && d[W-1-k] == m) k++;
    r.z = (k == W);
    r.c = r.z ? '0 : CW'(k);
    r.n = r.z ? d : (d << k);
    r.t = t;
    return r;
  endfunction

  function automatic res_t obs();
    return {bus.out_count, bus.out_zero, bus.out_norm, bus.out_tag};
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] d = W'($urandom);
    case ($urandom_range(0, 3))
      1:       d = d >> $urandom_range(0, W);
      2:       d = ~(d >> $urandom_range(0, W));
      3:       d = ($urandom_range(0, 1) == 1) ? 16'h0000 : 16'hFFFF;
      default: ;
    endcase
    return d;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] d, input logic m, input logic [TW-1:0] t);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_mode  = m;
    bus.in_tag   = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++;
    if (obs() !== res_t'(0)) begin bad++; $display("FAIL reset_outputs: got %h want 0", obs()); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single();
    res_t want = '{c: 4'd15, z: 1'b0, n: 16'h8000, t: 4'h3};
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h0001, 1'b0, 4'h3);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0);
    for (int i = 1; i < CW; i++) begin
      total++;
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL latency_early edge=%0d: got %b want 0", i, bus.out_valid); end
      @(negedge clk);
    end
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL latency_valid: got %b want 1", bus.out_valid); end
    total++;
    if (obs() !== want) begin bad++; $display("FAIL single_result: got %h want %h", obs(), want); end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || obs() !== want) begin
      bad++; $display("FAIL drained_hold: got v=%b %h want v=0 %h", bus.out_valid, obs(), want);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] din  [3] = '{16'h8000, 16'h0000, 16'h00F0};
    res_t         want [3] = '{'{4'd0, 1'b0, 16'h8000, 4'h5},
                               '{4'd0, 1'b1, 16'h0000, 4'h6},
                               '{4'd8, 1'b0, 16'hF000, 4'h7}};
    int got = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (c < 3) drive(1'b1, din[c], 1'b0, TW'(c + 5));
      else       drive(1'b0, '0, 1'b0, '0);
      #1;
      if (bus.out_valid === 1'b1) begin
        total++;
        if (obs() !== want[got] || c != CW + got) begin
          bad++; $display("FAIL b2b_word%0d: got %h at cycle %0d want %h at cycle %0d", got, obs(), c, want[got], CW + got);
        end
        got++;
      end
      @(negedge clk);
    end
    total++;
    if (got != 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", got); end
  endtask

  task automatic test_mode_mix();
    logic [W-1:0] din  [4] = '{16'hF0FF, 16'hFFFF, 16'h0FFF, 16'h0000};
    logic         mode [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    res_t         want [4] = '{'{4'd4, 1'b0, 16'h0FF0, 4'h9},
                               '{4'd0, 1'b1, 16'hFFFF, 4'hA},
                               '{4'd4, 1'b0, 16'hFFF0, 4'hB},
                               '{4'd0, 1'b0, 16'h0000, 4'hC}};
    int got = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (c < 4) drive(1'b1, din[c], mode[c], TW'(c + 9));
      else       drive(1'b0, '0, 1'b0, '0);
      #1;
      if (bus.out_valid === 1'b1) begin
        total++;
        if (obs() !== want[got] || c != CW + got) begin
          bad++; $display("FAIL mode_word%0d: got %h at cycle %0d want %h at cycle %0d", got, obs(), c, want[got], CW + got);
        end
        got++;
      end
      @(negedge clk);
    end
    total++;
    if (got != 4) begin bad++; $display("FAIL mode_count: got %0d want 4", got); end
  endtask

  task automatic test_stall();
    int sent = 0;
    int got  = 0;
    exp_q.delete();
    for (int c = 0; c < 60 && got < 8; c++) begin
      bus.out_ready = !(c >= 5 && c <= 7);
      if (sent < 8) drive(1'b1, rand_word(), 1'($urandom), TW'(sent));
      else          drive(1'b0, '0, 1'b0, '0);
      #1;
      total++;
      if (bus.in_ready !== ((c < 5 || c > 7) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL stall_in_ready cycle=%0d: got %b want %b", c, bus.in_ready, (c < 5 || c > 7));
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_data, bus.in_mode, bus.in_tag));
        sent++;
      end
      if (bus.out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0 || obs() !== exp_q[0]) begin
          bad++; $display("FAIL stall_word%0d cycle=%0d: got %h want %h", got, c, obs(), (exp_q.size() != 0) ? exp_q[0] : res_t'(0));
        end
        if (bus.out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          got++;
        end
      end
      @(negedge clk);
    end
    total++;
    if (got != 8 || exp_q.size() != 0) begin bad++; $display("FAIL stall_count: got %0d left %0d want 8 left 0", got, exp_q.size()); end
  endtask

  task automatic test_random();
    int sent = 0;
    int got  = 0;
    int errs = 0;
    exp_q.delete();
    for (int c = 0; c < NRAND * 4 && got < NRAND; c++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (sent < NRAND && $urandom_range(0, 3) != 0) drive(1'b1, rand_word(), 1'($urandom), TW'($urandom));
      else                                          drive(1'b0, '0, 1'b0, '0);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_data, bus.in_mode, bus.in_tag));
        sent++;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        total++;
        if (exp_q.size() == 0 || obs() !== exp_q[0]) begin
          bad++;
          if (errs < 10) $display("FAIL random_word%0d: got %h want %h", got, obs(), (exp_q.size() != 0) ? exp_q[0] : res_t'(0));
          errs++;
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      @(negedge clk);
    end
    total++;
    if (got != NRAND || exp_q.size() != 0) begin bad++; $display("FAIL random_count: got %0d left %0d want %0d left 0", got, exp_q.size(), NRAND); end
  endtask

  task automatic test_reset_flight();
    int seen = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 16'h0100 << c, 1'b0, TW'(c + 1));
      @(negedge clk);
    end
    drive(1'b0, '0, 1'b0, '0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flight_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flight_out_valid: got %b want 0", bus.out_valid); end
    total++;
    if (obs() !== res_t'(0)) begin bad++; $display("FAIL flight_outputs: got %h want 0", obs()); end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL flight_stale: got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    test_reset();
    test_single();
    test_back_to_back();
    test_mode_mix();
    test_stall();
    test_random();
    test_reset_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
